// File: rtl/neural_ctrl_pkg.sv
// Shared constants for the neuron sequencing controller: opcodes, state encoding, default widths.
// The optional stall counter is enabled with the NEURAL_CTRL_STALL_CNT_EN macro (see neural_seq_controller).
package neural_ctrl_pkg;

  localparam int IMM_W_DEF   = 16;
  localparam int OPC_W_DEF   = 2;
  localparam int STALL_W_DEF = 32;

  localparam logic [1:0] OPC_I = 2'b00;
  localparam logic [1:0] OPC_M = 2'b01;
  localparam logic [1:0] OPC_A = 2'b10;
  localparam logic [1:0] OPC_F = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_MACC  = 3'd2,
    ST_ACT   = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

endpackage

// File: rtl/neural_rep_counter.sv
// Loadable repeat down-counter: a load of zero becomes one, decrements stop at zero,
// and last flags the final remaining beat.
module neural_rep_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= (load_val == '0) ? W'(1) : load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/neural_seq_controller.sv
// Instruction-driven sequencer for the neuron MACC datapath (INIT, MACC bursts, ACT, FLUSH).
// Define NEURAL_CTRL_STALL_CNT_EN to add the saturating stall_cnt output.
module neural_seq_controller
  import neural_ctrl_pkg::*;
#(
  parameter int IMM_W = IMM_W_DEF,
  parameter int OPC_W = OPC_W_DEF
`ifdef NEURAL_CTRL_STALL_CNT_EN
  , parameter int STALL_W = STALL_W_DEF
`endif
) (
  input  logic               clk,
  input  logic               reset,
  // Handshake: an instruction transfers in any cycle where instr_valid && instr_ready;
  // instr_ready is high only in IDLE and never during reset.
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [IMM_W-1:0]   imm,
  input  logic               input_fifo_empty,
  input  logic               work_fifo_empty,
  input  logic               work_fifo_full,
  output logic               macc_clr,
  output logic               macc_en,
  output logic               macc_de,
  output logic               input_de,
  output logic               work_de,
  output logic               work_en,
  output logic               busy,
  output logic               done,
`ifdef NEURAL_CTRL_STALL_CNT_EN
  output logic [STALL_W-1:0] stall_cnt,
`endif
  output logic [2:0]         dbg_state
);

  state_t           state;
  logic             act_wr;
  logic [IMM_W-1:0] rem;
  logic             rem_last;
  logic             accept;
  logic             macc_xfer;
  logic             act_stall;
  logic             flush_done;

  assign instr_ready = (state == ST_IDLE) && !reset;
  assign accept      = instr_valid && instr_ready;
  assign macc_xfer   = (state == ST_MACC) && (!input_fifo_empty || !work_fifo_empty);
  assign act_stall   = (state == ST_ACT) && act_wr && work_fifo_full;
  assign flush_done  = (state == ST_FLUSH) && input_fifo_empty && work_fifo_empty;
  assign dbg_state   = state;

  neural_rep_counter #(.W(IMM_W)) u_rep (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && (opcode == OPC_W'(OPC_M))),
    .load_val (imm),
    .dec      (macc_xfer),
    .count    (rem),
    .last     (rem_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      act_wr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            act_wr <= |imm;
            if (opcode == OPC_W'(OPC_I))      state <= ST_INIT;
            else if (opcode == OPC_W'(OPC_M)) state <= ST_MACC;
            else if (opcode == OPC_W'(OPC_A)) state <= ST_ACT;
            else                              state <= ST_FLUSH;
          end
        end
        ST_INIT:  state <= ST_IDLE;
        ST_MACC:  if (macc_xfer && rem_last) state <= ST_IDLE;
        ST_ACT:   if (!act_stall) state <= ST_IDLE;
        ST_FLUSH: if (flush_done) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Strobes follow the live FIFO flags; reset masks them so an abandoned burst emits nothing.
  always_comb begin
    macc_clr = 1'b0;
    macc_en  = 1'b0;
    macc_de  = 1'b0;
    input_de = 1'b0;
    work_de  = 1'b0;
    work_en  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    if (!reset) begin
      busy = (state != ST_IDLE);
      case (state)
        ST_INIT: begin
          macc_clr = 1'b1;
          macc_en  = 1'b1;
        end
        ST_MACC: begin
          if (!input_fifo_empty) begin
            input_de = 1'b1;
            macc_de  = 1'b1;
            macc_en  = 1'b1;
          end else if (!work_fifo_empty) begin
            work_de = 1'b1;
            macc_de = 1'b1;
            macc_en = 1'b1;
          end
        end
        ST_ACT: begin
          if (!act_stall) begin
            macc_de = 1'b1;
            work_en = act_wr;
          end
        end
        ST_FLUSH: done = flush_done;
        default: ;
      endcase
    end
  end

`ifdef NEURAL_CTRL_STALL_CNT_EN
  logic macc_stall;
  assign macc_stall = (state == ST_MACC) && input_fifo_empty && work_fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((macc_stall || act_stall) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_neural_seq_controller.sv
// Bench for neural_seq_controller: directed cycle table followed by randomized traffic
// checked against a transaction-level model.
module tb_neural_seq_controller;

  localparam int IMM_W = 16;
  localparam int OPC_W = 2;

  localparam logic [8:0] O_RDY  = 9'h100;
  localparam logic [8:0] O_BSY  = 9'h080;
  localparam logic [8:0] O_CLR  = 9'h040;
  localparam logic [8:0] O_EN   = 9'h020;
  localparam logic [8:0] O_DE   = 9'h010;
  localparam logic [8:0] O_IDE  = 9'h008;
  localparam logic [8:0] O_WDE  = 9'h004;
  localparam logic [8:0] O_WEN  = 9'h002;
  localparam logic [8:0] O_DONE = 9'h001;
  localparam logic [8:0] X_IN   = O_BSY | O_EN | O_DE | O_IDE;
  localparam logic [8:0] X_WK   = O_BSY | O_EN | O_DE | O_WDE;

  logic             clk = 1'b0;
  logic             reset;
  logic             instr_valid;
  logic             instr_ready;
  logic [OPC_W-1:0] opcode;
  logic [IMM_W-1:0] imm;
  logic             input_fifo_empty;
  logic             work_fifo_empty;
  logic             work_fifo_full;
  logic             macc_clr, macc_en, macc_de, input_de, work_de, work_en, busy, done;
  logic [2:0]       dbg_state;
`ifdef NEURAL_CTRL_STALL_CNT_EN
  logic [31:0]      stall_cnt;
`endif
  logic [8:0]       outs;

  assign outs = {instr_ready, busy, macc_clr, macc_en, macc_de, input_de, work_de, work_en, done};

  neural_seq_controller #(.IMM_W(IMM_W), .OPC_W(OPC_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .opcode           (opcode),
    .imm              (imm),
    .input_fifo_empty (input_fifo_empty),
    .work_fifo_empty  (work_fifo_empty),
    .work_fifo_full   (work_fifo_full),
    .macc_clr         (macc_clr),
    .macc_en          (macc_en),
    .macc_de          (macc_de),
    .input_de         (input_de),
    .work_de          (work_de),
    .work_en          (work_en),
    .busy             (busy),
    .done             (done),
`ifdef NEURAL_CTRL_STALL_CNT_EN
    .stall_cnt        (stall_cnt),
`endif
    .dbg_state        (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] opc;
    int         imm;
    logic       ie;
    logic       we;
    logic       wf;
    logic [8:0] exp;
    int         stall;
  } vec_t;

  vec_t       tbl[$];
  logic [8:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;

  function automatic void add(input logic rst, input logic vld, input logic [1:0] opc,
                              input int imv, input logic ie, input logic we, input logic wf,
                              input logic [8:0] exp, input int stall);
    vec_t v;
    v.rst = rst; v.vld = vld; v.opc = opc; v.imm = imv;
    v.ie = ie; v.we = we; v.wf = wf; v.exp = exp; v.stall = stall;
    tbl.push_back(v);
  endfunction

  // Driver: new inputs land just after the rising edge.
  task automatic drive(input logic rst, input logic vld, input logic [1:0] opc, input int imv,
                       input logic ie, input logic we, input logic wf);
    @(posedge clk);
    #1;
    reset            = rst;
    instr_valid      = vld;
    opcode           = opc;
    imm              = IMM_W'(imv);
    input_fifo_empty = ie;
    work_fifo_empty  = we;
    work_fifo_full   = wf;
  endtask

  // Scoreboard: compare on the falling edge against the head of the expected queue.
  task automatic check_outs(input string name);
    logic [8:0] e;
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (outs !== e) begin
      bad++;
      $display("FAIL %s: got rdy,bsy,clr,en,de,ide,wde,wen,done=%b expected %b", name, outs, e);
    end
  endtask

  task automatic check_stall(input string name, input longint exp_val);
`ifdef NEURAL_CTRL_STALL_CNT_EN
    total++;
    if (stall_cnt !== 32'(exp_val)) begin
      bad++;
      $display("FAIL %s: stall_cnt got %0d expected %0d", name, stall_cnt, exp_val);
    end
`else
    if (exp_val < 0) $display("unexpected stall expectation in %s", name);
`endif
  endtask

  int         m_kind;
  int         m_left;
  bit         m_wr;
  longint     m_stall;
  logic       r_rst, r_vld, r_ie, r_we, r_wf;
  logic [1:0] r_opc;
  int         r_imm;
  logic [8:0] e;

  initial begin
    reset = 1'b1; instr_valid = 1'b0; opcode = '0; imm = '0;
    input_fifo_empty = 1'b1; work_fifo_empty = 1'b1; work_fifo_full = 1'b0;

    // Reset held three cycles, ready right after release
    add(1, 0, 0, 0, 1, 1, 0, 9'h000, -1);
    add(1, 0, 0, 0, 0, 0, 0, 9'h000, -1);
    add(1, 1, 1, 4, 0, 0, 0, 9'h000, -1);
    add(0, 0, 0, 0, 1, 1, 0, O_RDY, 0);
    // M imm=4 from the input FIFO
    add(0, 1, 1, 4, 1, 1, 0, O_RDY, -1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 1, 0, X_IN, -1);
    add(0, 0, 0, 0, 1, 1, 0, O_RDY, -1);
    // M imm=3: one work beat, two stalls, two input beats
    add(0, 1, 1, 3, 1, 1, 0, O_RDY, -1);
    add(0, 0, 0, 0, 1, 0, 0, X_WK, -1);
    add(0, 0, 0, 0, 1, 1, 0, O_BSY, -1);
    add(0, 0, 0, 0, 1, 1, 0, O_BSY, -1);
    add(0, 0, 0, 0, 0, 0, 0, X_IN, -1);
    add(0, 0, 0, 0, 0, 1, 0, X_IN, -1);
    add(0, 0, 0, 0, 1, 1, 0, O_RDY, 2);
    // M imm=0 gives exactly one transfer
    add(0, 1, 1, 0, 1, 1, 0, O_RDY, -1);
    add(0, 0, 0, 0, 0, 1, 0, X_IN, -1);
    add(0, 0, 0, 0, 0, 0, 0, O_RDY, -1);
    // A imm=1 against a full work FIFO for five cycles; valid held while busy is ignored
    add(0, 1, 2, 1, 1, 1, 0, O_RDY, -1);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 1, 1, 1, O_BSY, -1);
    add(0, 0, 0, 0, 1, 1, 0, O_BSY | O_DE | O_WEN, -1);
    add(0, 0, 0, 0, 1, 1, 0, O_RDY, 7);
    // A imm=0 never writes, even when full
    add(0, 1, 2, 0, 1, 1, 1, O_RDY, -1);
    add(0, 0, 0, 0, 1, 1, 1, O_BSY | O_DE, -1);
    add(0, 0, 0, 0, 1, 1, 1, O_RDY, 7);
    // F waits out a non-empty work FIFO
    add(0, 1, 3, 0, 1, 1, 0, O_RDY, -1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 0, 0, O_BSY, -1);
    add(0, 0, 0, 0, 1, 1, 0, O_BSY | O_DONE, -1);
    add(0, 0, 0, 0, 1, 1, 0, O_RDY, -1);
    // Reset mid-burst at rem=2, then an I instruction
    add(0, 1, 1, 4, 1, 1, 0, O_RDY, -1);
    add(0, 0, 0, 0, 0, 1, 0, X_IN, -1);
    add(0, 0, 0, 0, 0, 1, 0, X_IN, -1);
    add(1, 0, 0, 0, 0, 1, 0, 9'h000, -1);
    add(0, 0, 0, 0, 0, 1, 0, O_RDY, 0);
    add(0, 1, 0, 0, 0, 0, 0, O_RDY, -1);
    add(0, 0, 0, 0, 0, 0, 0, O_BSY | O_CLR | O_EN, -1);
    add(0, 0, 0, 0, 0, 0, 0, O_RDY, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].opc, tbl[i].imm, tbl[i].ie, tbl[i].we, tbl[i].wf);
      exp_q.push_back(tbl[i].exp);
      check_outs($sformatf("vec%0d", i));
      if (tbl[i].stall >= 0) check_stall($sformatf("vec%0d_stall", i), longint'(tbl[i].stall));
      if (!tbl[i].rst && tbl[i].exp == O_RDY) begin
        total++;
        if (dbg_state !== 3'd0) begin
          bad++;
          $display("FAIL vec%0d_state: dbg_state got %0d expected 0", i, dbg_state);
        end
      end
    end

    // Randomized traffic against a transaction-level model
    m_kind = 0; m_left = 0; m_wr = 0; m_stall = 0;
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_vld = 1'($urandom_range(0, 1));
      r_opc = 2'($urandom_range(0, 3));
      r_imm = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 6));
      r_ie  = ($urandom_range(0, 2) == 0);
      r_we  = ($urandom_range(0, 2) == 0);
      r_wf  = ($urandom_range(0, 2) == 0);
      drive(r_rst, r_vld, r_opc, r_imm, r_ie, r_we, r_wf);

      e = 9'h000;
      if (r_rst) begin
        m_kind = 0;
      end else begin
        case (m_kind)
          0: begin
            e = O_RDY;
            if (r_vld) begin
              m_kind = int'(r_opc) + 1;
              m_left = (r_imm == 0) ? 1 : r_imm;
              m_wr   = (r_imm != 0);
            end
          end
          1: begin
            e = O_BSY | O_CLR | O_EN;
            m_kind = 0;
          end
          2: begin
            e = O_BSY;
            if (!r_ie)      e = X_IN;
            else if (!r_we) e = X_WK;
            if (!r_ie || !r_we) begin
              m_left--;
              if (m_left == 0) m_kind = 0;
            end
          end
          3: begin
            e = O_BSY;
            if (!m_wr) begin
              e = O_BSY | O_DE;
              m_kind = 0;
            end else if (!r_wf) begin
              e = O_BSY | O_DE | O_WEN;
              m_kind = 0;
            end
          end
          default: begin
            e = O_BSY;
            if (r_ie && r_we) begin
              e = O_BSY | O_DONE;
              m_kind = 0;
            end
          end
        endcase
      end
      exp_q.push_back(e);
      check_outs($sformatf("rnd%0d", c));
      check_stall($sformatf("rnd%0d_stall", c), m_stall);
      // Stall count the DUT will show from the next cycle on
      if (r_rst) m_stall = 0;
      else if ((e == O_BSY) && (m_kind == 2 || m_kind == 3)) m_stall++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
